// File: rtl/input_vc_buffer.sv
// Input-port VC buffer: per-VC FIFOs with XY route compute on head flits,
// grant-driven pop toward the crossbar and per-VC credit return upstream.
package params_noc;
    typedef logic [2:0] inout_Port;
    localparam inout_Port LOCAL = 3'd0;
    localparam inout_Port NORTH = 3'd1;
    localparam inout_Port SOUTH = 3'd2;
    localparam inout_Port WEST  = 3'd3;
    localparam inout_Port EAST  = 3'd4;
endpackage

// One VC: FIFO plus IDLE/ACTIVE packet FSM and the registered route.
module input_vc_buffer_vc
    import params_noc::*;
#(
    parameter int buf_Depth  = 4,
    parameter int flit_Width = 32,
    parameter int coord_W    = 3,
    parameter int x_Cur      = 0,
    parameter int y_Cur      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [flit_Width-1:0] i_flit,
    input  logic                  i_gnt,
    output logic                  o_req,
    output inout_Port             o_port,
    output logic [flit_Width-1:0] o_front,
    output logic                  o_drop,
    output logic                  o_discard
);
    localparam int AW = $clog2(buf_Depth);
    localparam logic [coord_W-1:0] XC = coord_W'(x_Cur);
    localparam logic [coord_W-1:0] YC = coord_W'(y_Cur);

    typedef enum logic {IDLE, ACTIVE} vc_state_t;

    logic [flit_Width-1:0] r_mem [buf_Depth];
    logic [AW:0]           r_wr_ptr, r_rd_ptr;
    vc_state_t             r_state, w_state_nxt;
    inout_Port             r_port, w_route;
    logic                  w_empty, w_full, w_pop, w_wr_en, w_route_en;
    logic [1:0]            w_type;
    logic [coord_W-1:0]    w_dx, w_dy;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_front = r_mem[r_rd_ptr[AW-1:0]];
    assign w_type  = o_front[flit_Width-1 -: 2];
    assign w_dx    = o_front[2*coord_W-1:coord_W];
    assign w_dy    = o_front[coord_W-1:0];

    // A pop in the same cycle frees the slot, so push into full is legal then.
    assign w_wr_en = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;
    assign o_req   = (r_state == ACTIVE) && !w_empty;
    assign o_port  = r_port;

    always_comb begin
        w_route = LOCAL;
        if (w_dx > XC)      w_route = EAST;
        else if (w_dx < XC) w_route = WEST;
        else if (w_dy > YC) w_route = NORTH;
        else if (w_dy < YC) w_route = SOUTH;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_route_en  = 1'b0;
        o_discard   = 1'b0;
        case (r_state)
            IDLE: if (!w_empty) begin
                if (w_type[0]) begin
                    w_route_en  = 1'b1;
                    w_state_nxt = ACTIVE;
                end else begin
                    w_pop     = 1'b1;
                    o_discard = 1'b1;
                end
            end
            ACTIVE: if (i_gnt && !w_empty) begin
                w_pop = 1'b1;
                if (w_type[1]) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_port   <= LOCAL;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_route_en) r_port   <= w_route;
            if (w_wr_en)    r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_flit;
    end
endmodule

module input_vc_buffer
    import params_noc::*;
#(
    parameter int vc_Num     = 4,
    parameter int buf_Depth  = 4,
    parameter int flit_Width = 32,
    parameter int coord_W    = 3,
    parameter int x_Cur      = 0,
    parameter int y_Cur      = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_i,
    input  logic [$clog2(vc_Num)-1:0]   vc_id_i,
    input  logic [flit_Width-1:0]       flit_i,
    output logic [vc_Num-1:0]           request_o,
    output inout_Port [vc_Num-1:0]      out_port_o,
    input  logic [vc_Num-1:0]           grant_i,
    output logic                        valid_o,
    output logic [$clog2(vc_Num)-1:0]   vc_id_o,
    output logic [flit_Width-1:0]       flit_o,
    output logic [vc_Num-1:0]           credit_o,
    output logic                        err_o
);
    localparam int VW = $clog2(vc_Num);
    localparam logic [vc_Num-1:0] ONE = vc_Num'(1);

    logic [vc_Num-1:0]                 w_push, w_drop, w_discard;
    logic [vc_Num-1:0]                 w_gnt_req, w_gnt_oh;
    logic [vc_Num-1:0][flit_Width-1:0] w_front;
    logic [VW-1:0]                     w_sel;
    logic                              w_multi;

    logic                  r_valid, r_err;
    logic [VW-1:0]         r_vc_id;
    logic [flit_Width-1:0] r_flit;
    logic [vc_Num-1:0]     r_credit;

    // Grants without a live request are ignored; lowest requesting VC wins.
    assign w_gnt_req = grant_i & request_o;
    assign w_gnt_oh  = w_gnt_req & (~w_gnt_req + ONE);
    assign w_multi   = |(grant_i & (grant_i - ONE));

    always_comb begin
        w_sel = '0;
        for (int v = vc_Num - 1; v >= 0; v--)
            if (w_gnt_req[v]) w_sel = VW'(v);
    end

    for (genvar v = 0; v < vc_Num; v++) begin : g_vc
        assign w_push[v] = valid_i && (vc_id_i == VW'(v));
        input_vc_buffer_vc #(
            .buf_Depth (buf_Depth),
            .flit_Width(flit_Width),
            .coord_W   (coord_W),
            .x_Cur     (x_Cur),
            .y_Cur     (y_Cur)
        ) u_vc (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_push   (w_push[v]),
            .i_flit   (flit_i),
            .i_gnt    (w_gnt_oh[v]),
            .o_req    (request_o[v]),
            .o_port   (out_port_o[v]),
            .o_front  (w_front[v]),
            .o_drop   (w_drop[v]),
            .o_discard(w_discard[v])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_vc_id  <= '0;
            r_flit   <= '0;
            r_credit <= '0;
            r_err    <= 1'b0;
        end else begin
            r_valid  <= |w_gnt_oh;
            r_credit <= w_gnt_oh;
            if (|w_gnt_oh) begin
                r_flit  <= w_front[w_sel];
                r_vc_id <= w_sel;
            end
            r_err <= r_err | (|w_drop) | (|w_discard) | w_multi;
        end
    end

    assign valid_o  = r_valid;
    assign vc_id_o  = r_vc_id;
    assign flit_o   = r_flit;
    assign credit_o = r_credit;
    assign err_o    = r_err;
endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer at router (1,1): routing, packets,
// FIFO-full handling, VC interleave, protocol error and async reset.
module tb_input_vc_buffer;
    localparam int VN = 4;
    localparam int FW = 32;
    localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HT = 2'b11;
    localparam logic [2:0] P_LOCAL = 3'd0, P_NORTH = 3'd1, P_SOUTH = 3'd2, P_EAST = 3'd4;

    logic                 clk = 1'b0, rst_n = 1'b1, valid_i = 1'b0;
    logic [1:0]           vc_id_i = '0;
    logic [FW-1:0]        flit_i = '0;
    logic [VN-1:0]        grant_i = '0;
    logic [VN-1:0]        request_o, credit_o;
    logic [VN-1:0][2:0]   out_port_o;
    logic                 valid_o, err_o;
    logic [1:0]           vc_id_o;
    logic [FW-1:0]        flit_o;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    input_vc_buffer #(.vc_Num(VN), .buf_Depth(4), .flit_Width(FW), .coord_W(3),
                      .x_Cur(1), .y_Cur(1)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .vc_id_i(vc_id_i), .flit_i(flit_i),
        .request_o(request_o), .out_port_o(out_port_o), .grant_i(grant_i),
        .valid_o(valid_o), .vc_id_o(vc_id_o), .flit_o(flit_o), .credit_o(credit_o),
        .err_o(err_o));

    function automatic logic [FW-1:0] mkf(input logic [1:0] t, input logic [23:0] tag,
                                          input logic [2:0] x, input logic [2:0] y);
        return {t, tag, x, y};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] id, input logic [FW-1:0] f,
                         input logic [VN-1:0] g);
        valid_i = v; vc_id_i = id; flit_i = f; grant_i = g;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; drive(0, 0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (request_o !== 4'b0) begin errors++; $display("FAIL reset_req: got %b exp 0000", request_o); end
        checks++; if (out_port_o !== 12'h0) begin errors++; $display("FAIL reset_port: got %h exp 000", out_port_o); end
        checks++; if ({valid_o, vc_id_o, credit_o, err_o} !== 8'h0) begin errors++; $display("FAIL reset_ctl: got %b exp 0", {valid_o, vc_id_o, credit_o, err_o}); end
        checks++; if (flit_o !== '0) begin errors++; $display("FAIL reset_flit: got %h exp 0", flit_o); end
        do_reset();
    endtask

    task automatic test_single();
        logic [FW-1:0] f;
        f = mkf(HT, 24'h0000A1, 3'd3, 3'd1);
        drive(1, 2, f, '0); tick();
        drive(0, 0, '0, '0);
        checks++; if (request_o !== 4'b0000) begin errors++; $display("FAIL single_early_req: got %b exp 0000", request_o); end
        tick();
        checks++; if (out_port_o[2] !== P_EAST) begin errors++; $display("FAIL single_port: got %0d exp %0d", out_port_o[2], P_EAST); end
        checks++; if (request_o !== 4'b0100) begin errors++; $display("FAIL single_req: got %b exp 0100", request_o); end
        drive(0, 0, '0, 4'b0100); tick();
        drive(0, 0, '0, '0);
        checks++; if ({valid_o, vc_id_o} !== 3'b110) begin errors++; $display("FAIL single_pop: got valid=%b vc=%0d exp valid=1 vc=2", valid_o, vc_id_o); end
        checks++; if (flit_o !== f) begin errors++; $display("FAIL single_flit: got %h exp %h", flit_o, f); end
        checks++; if (credit_o !== 4'b0100) begin errors++; $display("FAIL single_credit: got %b exp 0100", credit_o); end
        checks++; if (request_o !== 4'b0000) begin errors++; $display("FAIL single_req_drop: got %b exp 0000", request_o); end
        tick();
        checks++; if ({valid_o, credit_o} !== 5'b0) begin errors++; $display("FAIL single_pulse: got valid=%b credit=%b exp 0/0000", valid_o, credit_o); end
    endtask

    task automatic test_packet();
        logic [FW-1:0] pkt [4];
        int got = 0, cred = 0, first = -1, last = -1;
        pkt[0] = mkf(HEAD, 24'h000B01, 3'd1, 3'd0);
        pkt[1] = mkf(BODY, 24'h000B02, 3'd0, 3'd0);
        pkt[2] = mkf(BODY, 24'h000B03, 3'd0, 3'd0);
        pkt[3] = mkf(TAIL, 24'h000B04, 3'd0, 3'd0);
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c < 4) drive(1, 0, pkt[c], 4'b0001); else drive(0, 0, '0, 4'b0001);
            tick();
            if (valid_o === 1'b1) begin
                if (got < 4) begin
                    checks++; if ({vc_id_o, flit_o} !== {2'd0, pkt[got]}) begin errors++; $display("FAIL pkt_flit%0d: got vc=%0d %h exp vc=0 %h", got, vc_id_o, flit_o, pkt[got]); end
                end
                if (first < 0) first = c;
                last = c; got++;
            end
            if (credit_o === 4'b0001) cred++;
        end
        drive(0, 0, '0, '0);
        checks++; if (got !== 4) begin errors++; $display("FAIL pkt_count: got %0d exp 4", got); end
        checks++; if (cred !== 4) begin errors++; $display("FAIL pkt_credits: got %0d exp 4", cred); end
        checks++; if (last - first !== 3) begin errors++; $display("FAIL pkt_b2b: got span %0d exp 3", last - first); end
        checks++; if (out_port_o[0] !== P_SOUTH) begin errors++; $display("FAIL pkt_port: got %0d exp %0d", out_port_o[0], P_SOUTH); end
        checks++; if (request_o !== 4'b0000) begin errors++; $display("FAIL pkt_idle: got %b exp 0000", request_o); end
    endtask

    task automatic test_full();
        logic [FW-1:0] q [5];
        q[0] = mkf(HEAD, 24'h000C00, 3'd1, 3'd2);
        q[1] = mkf(BODY, 24'h000C01, 3'd0, 3'd0);
        q[2] = mkf(BODY, 24'h000C02, 3'd0, 3'd0);
        q[3] = mkf(BODY, 24'h000C03, 3'd0, 3'd0);
        q[4] = mkf(TAIL, 24'h000C04, 3'd0, 3'd0);
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, 1, q[i], '0); tick(); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_noerr4: got %b exp 0", err_o); end
        drive(1, 1, q[4], '0); tick();
        drive(0, 0, '0, '0);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL full_drop_err: got %b exp 1", err_o); end
        checks++; if (request_o !== 4'b0010) begin errors++; $display("FAIL full_req: got %b exp 0010", request_o); end

        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, 1, q[i], '0); tick(); end
        drive(1, 1, q[4], 4'b0010); tick();
        checks++; if ({valid_o, flit_o} !== {1'b1, q[0]}) begin errors++; $display("FAIL full_pushpop: got %b %h exp 1 %h", valid_o, flit_o, q[0]); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_pushpop_err: got %b exp 0", err_o); end
        for (int i = 1; i < 5; i++) begin
            drive(0, 0, '0, 4'b0010); tick();
            checks++; if ({valid_o, flit_o} !== {1'b1, q[i]}) begin errors++; $display("FAIL full_drain%0d: got %b %h exp 1 %h", i, valid_o, flit_o, q[i]); end
        end
        drive(0, 0, '0, '0); tick();
        checks++; if ({request_o, valid_o, err_o} !== 6'b0) begin errors++; $display("FAIL full_empty: got req=%b valid=%b err=%b exp 0", request_o, valid_o, err_o); end
    endtask

    task automatic test_interleave();
        logic [FW-1:0] ef [4];
        logic [VN-1:0] g [4];
        logic [1:0] ev [4];
        ef[0] = mkf(HEAD, 24'h000010, 3'd3, 3'd1); g[0] = 4'b0001; ev[0] = 2'd0;
        ef[1] = mkf(HEAD, 24'h000030, 3'd1, 3'd1); g[1] = 4'b1000; ev[1] = 2'd3;
        ef[2] = mkf(TAIL, 24'h000011, 3'd0, 3'd0); g[2] = 4'b0001; ev[2] = 2'd0;
        ef[3] = mkf(TAIL, 24'h000031, 3'd0, 3'd0); g[3] = 4'b1000; ev[3] = 2'd3;
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, ev[i], ef[i], '0); tick(); end
        drive(0, 0, '0, '0);
        checks++; if ({out_port_o[0], out_port_o[3]} !== {P_EAST, P_LOCAL}) begin errors++; $display("FAIL il_ports: got %0d/%0d exp 4/0", out_port_o[0], out_port_o[3]); end
        checks++; if (request_o !== 4'b1001) begin errors++; $display("FAIL il_req: got %b exp 1001", request_o); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, '0, g[i]); tick();
            checks++; if ({valid_o, vc_id_o, flit_o, credit_o} !== {1'b1, ev[i], ef[i], g[i]}) begin
                errors++; $display("FAIL il_pop%0d: got v=%b vc=%0d %h cr=%b exp vc=%0d %h cr=%b", i, valid_o, vc_id_o, flit_o, credit_o, ev[i], ef[i], g[i]);
            end
        end
        drive(0, 0, '0, '0); tick();
        checks++; if (request_o !== 4'b0000) begin errors++; $display("FAIL il_idle: got %b exp 0000", request_o); end
        checks++; if ({out_port_o[0], out_port_o[3]} !== {P_EAST, P_LOCAL}) begin errors++; $display("FAIL il_hold: got %0d/%0d exp 4/0", out_port_o[0], out_port_o[3]); end
    endtask

    task automatic test_proto();
        do_reset();
        drive(1, 1, mkf(BODY, 24'h000D01, 3'd2, 3'd2), '0); tick();
        drive(0, 0, '0, '0);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL proto_pre: got %b exp 0", err_o); end
        tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL proto_err: got %b exp 1", err_o); end
        checks++; if ({request_o, credit_o, valid_o} !== 9'b0) begin errors++; $display("FAIL proto_quiet: got req=%b cr=%b v=%b exp 0", request_o, credit_o, valid_o); end
        tick();
        checks++; if ({credit_o, valid_o} !== 5'b0) begin errors++; $display("FAIL proto_nocredit: got cr=%b v=%b exp 0", credit_o, valid_o); end
        drive(1, 1, mkf(HT, 24'h000D02, 3'd1, 3'd2), '0); tick();
        drive(0, 0, '0, '0); tick();
        checks++; if ({request_o, out_port_o[1]} !== {4'b0010, P_NORTH}) begin errors++; $display("FAIL proto_recover: got req=%b port=%0d exp 0010/1", request_o, out_port_o[1]); end
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] h, nf;
        h  = mkf(HEAD, 24'h000E01, 3'd3, 3'd1);
        nf = mkf(HT,   24'h000E77, 3'd1, 3'd2);
        do_reset();
        drive(1, 2, h, '0); tick();
        drive(1, 2, mkf(BODY, 24'h000E02, 3'd0, 3'd0), '0); tick();
        drive(1, 2, mkf(BODY, 24'h000E03, 3'd0, 3'd0), 4'b0100); tick();
        drive(0, 0, '0, '0);
        checks++; if ({valid_o, request_o, out_port_o[2]} !== {1'b1, 4'b0100, P_EAST}) begin errors++; $display("FAIL rst_pre: got v=%b req=%b port=%0d exp 1/0100/4", valid_o, request_o, out_port_o[2]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({request_o, out_port_o} !== 16'h0) begin errors++; $display("FAIL rst_async_rt: got req=%b port=%h exp 0", request_o, out_port_o); end
        checks++; if ({valid_o, vc_id_o, credit_o, err_o, flit_o} !== 40'h0) begin errors++; $display("FAIL rst_async_out: got v=%b vc=%0d cr=%b err=%b flit=%h exp 0", valid_o, vc_id_o, credit_o, err_o, flit_o); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        drive(1, 2, nf, '0); tick();
        drive(0, 0, '0, '0); tick();
        checks++; if ({request_o, out_port_o[2]} !== {4'b0100, P_NORTH}) begin errors++; $display("FAIL rst_reroute: got req=%b port=%0d exp 0100/1", request_o, out_port_o[2]); end
        drive(0, 0, '0, 4'b0100); tick();
        drive(0, 0, '0, '0);
        checks++; if ({valid_o, flit_o, credit_o} !== {1'b1, nf, 4'b0100}) begin errors++; $display("FAIL rst_newpop: got v=%b %h cr=%b exp 1 %h 0100", valid_o, flit_o, credit_o, nf); end
        checks++; if (request_o !== 4'b0000) begin errors++; $display("FAIL rst_flushed: got %b exp 0000", request_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_packet();
        test_full();
        test_interleave();
        test_proto();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_vc_buffer.md
# input_vc_buffer

Per-input-port virtual-channel buffer and route-compute stage, one instance per router input port, directly upstream of `in_out_allocator`. It stores arriving flits in per-VC FIFOs and performs XY route computation on each packet's head flit. It presents per-VC requests and output-port targets to the allocator, then on a grant pops the winning flit toward the crossbar and returns a credit upstream.

## Interface
- `vc_Num`, 4: virtual channels per port; must match the allocator.
- `buf_Depth`, 4: flits per VC FIFO; power of two, ≥2.
- `flit_Width`, 32: flit width in bits.
- `coord_W`, 3: width of each X/Y coordinate field.
- `x_Cur`, 0: this router's X coordinate.
- `y_Cur`, 0: this router's Y coordinate.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `valid_i`  in  1  flit arriving this cycle.
- `vc_id_i`  in  $clog2(vc_Num)  target VC of the arriving flit.
- `flit_i`  in  flit_Width  arriving flit.
- `request_o`  out  vc_Num  per-VC request; one row of allocator `request_in`.
- `out_port_o`  out  inout_Port [vc_Num-1:0]  routed output port per VC; one row of allocator `inports_Out`.
- `grant_i`  in  vc_Num  one-hot grant; one row of allocator `grant_o`.
- `valid_o`  out  1  registered flit toward the crossbar.
- `vc_id_o`  out  $clog2(vc_Num)  VC the output flit came from.
- `flit_o`  out  flit_Width  output flit.
- `credit_o`  out  vc_Num  one-cycle pulse per popped flit, per VC, to the upstream router.
- `err_o`  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- Flit type is `flit[flit_Width-1 -: 2]`:
  - 00 BODY
  - 01 HEAD
  - 10 TAIL
  - 11 HEADTAIL (single-flit packet).
- Head destination fields: X at `flit[2*coord_W-1:coord_W]`, Y at `flit[coord_W-1:0]`.
- `inout_Port` comes from `params_noc`, with encoding LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4.
- XY route:
  - destX > x_Cur → EAST.
  - destX < x_Cur → WEST.
  - Otherwise destY > y_Cur → NORTH, destY < y_Cur → SOUTH.
  - Otherwise LOCAL.
- Each VC runs a two-state FSM:
  - **IDLE**: when the FIFO is non-empty and the front flit is HEAD or HEADTAIL, compute the route, register it into `out_port_o[v]`, and go to ACTIVE.
  - **IDLE, error case**: when the front flit is BODY or TAIL, pop and discard it, set `err_o`, and send no credit.
  - **ACTIVE**: `request_o[v]` = FIFO non-empty. When `grant_i[v]` is set, pop the front flit.
  - **ACTIVE → IDLE**: taken when the popped flit is TAIL or HEADTAIL.
- `out_port_o[v]` holds its value until the next head is routed.
- Push: on `valid_i`, write `flit_i` into FIFO `vc_id_i`.
  - If the FIFO is full and not popping in the same cycle, drop the flit and set `err_o`.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Grant handling:
  - A grant bit with `request_o` low is ignored.
  - If `grant_i` is multi-hot, serve the lowest-index requesting VC and set `err_o`.
- Pop: register the flit into `flit_o`, its VC into `vc_id_o`, set `valid_o`, and pulse `credit_o[v]`, all on the edge after the grant.
- FIFO pointers use `$clog2(buf_Depth)+1` bits; the MSB distinguishes full from empty across wrap-around.

## Timing
- Reset (async assert, synchronous deassert by the integrating logic) sets:
  - all FIFOs empty, all VCs IDLE
  - `request_o`=0, `out_port_o`=LOCAL for all VCs
  - `valid_o`=0, `vc_id_o`=0, `flit_o`=0, `credit_o`=0, `err_o`=0
- Reset mid-packet discards all buffered flits; no credits are issued for them.
- Head pushed at edge t: visible at the FIFO front after t, route registered and ACTIVE at t+1, `request_o` high during cycle t+1→t+2.
- Grant sampled at edge g: `valid_o`/`flit_o`/`credit_o` valid after g for exactly one cycle unless a new pop occurs.
- A grant must only be taken when `request_o` was high in the same cycle. `request_o` drops in the cycle after the last buffered flit is popped.
- Back-to-back pops on the same VC are allowed every cycle; throughput is 1 flit/cycle per port.
- After a TAIL pop, a following HEAD already at the front is routed the next cycle, giving a one-cycle bubble per packet boundary.

## Test plan
- **Single-flit route:** x_Cur=1, y_Cur=1. HEADTAIL to (3,1) on VC2 → `out_port_o[2]`=EAST, `request_o`=4'b0100. Grant 4'b0100 → next cycle `valid_o`=1, `vc_id_o`=2, `credit_o`=4'b0100; VC2 returns to IDLE and `request_o`=0.
- **4-flit packet:** HEAD(1,0) BODY BODY TAIL on VC0 at x_Cur=1, y_Cur=1 → `out_port_o[0]`=SOUTH. With grants held every cycle, 4 consecutive `valid_o` cycles in order, 4 credit pulses, then IDLE.
- **Full FIFO:** buf_Depth=4, push 5 flits to VC1 without grant → 5th dropped, `err_o`=1. Then pushing into full while granting → occupancy stays 4, no error.
- **Interleaved VCs:** VC0 routed EAST and VC3 routed LOCAL, grants alternating 0001/1000 → flits leave in grant order with the correct `vc_id_o`, and route fields are not crossed between VCs.
- **Protocol error:** BODY arrives on an IDLE VC → discarded, `err_o`=1, no request, no credit.
- **Reset mid-packet:** HEAD+BODY buffered on VC2, then `rst_n`=0 asynchronously → outputs reach their reset values immediately; after release, a new HEADTAIL is routed normally.
